memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute pipeline-register outputs and performs data-memory load/store and stack push/pop through a synchronous-write, combinational-read data-memory port.
- Owns the stack pointer (SP).
- Registers results into the MEM/WB buffer. Two-word (32-bit PC) stack transfers take two cycles and stall upstream.

Parameters:
- ADDR_W, 12, data-memory word-address width.
- SP_INIT, 12'hFFF, SP value after reset. Stack grows toward lower addresses.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ex_result  in  16  ALU result
- ex_read_data1  in  16  Rdest value
- ex_read_data2  in  16  Rsrc value
- ex_pc_plus_one  in  32  return address
- ex_flags  in  3  {C,N,Z}
- ex_mem_read, ex_mem_write, ex_mem_push, ex_mem_pop  in  1 each  access controls
- ex_addr_sel  in  2  00 ex_result, 01 ex_read_data1, 10 stack, 11 reserved (treated as 00)
- ex_wsrc_sel  in  2  00 ex_read_data2, 01 ex_read_data1, 10 PC two-word, 11 {13'b0,ex_flags}
- ex_pc_choose_memory  in  1  pop is a 32-bit PC pop (RET/RTI)
- ex_reg_write  in  1  pass-through
- ex_reg_write_address  in  3  pass-through
- ex_wb_sel  in  2  pass-through
- ex_ldm_value  in  16  pass-through
- ex_input_port  in  16  pass-through
- dmem_addr  out  ADDR_W  memory address (combinational)
- dmem_wdata  out  16  write data (combinational)
- dmem_we  out  1  write strobe (combinational)
- dmem_rdata  in  16  read data, same cycle
- stall  out  1  hold upstream stage (combinational from state/inputs)
- mem_data_out  out  16  registered load/pop data
- pc_out  out  32  registered popped PC
- pc_load_out  out  1  registered one-cycle PC-redirect pulse
- result_out  out  16  registered ex_result
- reg_write_out  out  1  registered
- reg_write_address_out  out  3  registered
- wb_sel_out  out  2  registered
- ldm_value_out  out  16  registered
- input_port_out  out  16  registered
- sp_out  out  ADDR_W  current SP

Behaviour:
- Reset (async, reset==0):
  - SP=SP_INIT, state IDLE.
  - All registered outputs 0, stall 0.
- Address is taken from the low ADDR_W bits of the selected source.
- Priority when multiple controls are asserted: push > pop > write > read. Lower-priority requests are ignored.
- Single-word ops (load, store, one-word push/pop) complete in IDLE, 1-cycle latency:
  - Store: dmem_we=1, dmem_wdata per ex_wsrc_sel.
  - Load: mem_data_out <= dmem_rdata at the edge.
  - Push: write at SP, SP <= SP-1.
  - Pop: address SP+1, mem_data_out <= dmem_rdata, SP <= SP+1.
- PC push (push with ex_wsrc_sel=10) uses the FSM IDLE -> PUSH_LO -> IDLE:
  - IDLE cycle: write ex_pc_plus_one[31:16] at SP, SP-1, stall=1, WB regs get a bubble (reg_write_out=0, pc_load_out=0).
  - PUSH_LO cycle: write [15:0] at SP, SP-1, stall=0, pass-throughs registered.
- PC pop (pop with ex_pc_choose_memory=1) uses the FSM IDLE -> POP_HI -> IDLE:
  - IDLE cycle: read SP+1 into an internal low-half holding reg, SP+1, stall=1, bubble.
  - POP_HI cycle: read SP+1 (SP already advanced), pc_out <= {dmem_rdata, low half}, pc_load_out <= 1, SP+1.
- Upstream holds ex_* stable while stall=1. In the second state the block uses the held ex_* values; it does not re-latch them.
- SP arithmetic is modulo 2^ADDR_W: push at 0 wraps to 2^ADDR_W-1, pop at 2^ADDR_W-1 wraps to 0.
- pc_load_out is high for exactly one cycle per PC pop.
- Reset asserted mid two-word op returns the FSM to IDLE immediately and restores SP=SP_INIT. The partial memory write is not undone.
- No access: dmem_we=0, dmem_addr = ex_result bits, pass-throughs registered each cycle.

Optional Feature:
- Macro STACK_GUARD_EN.
- Defined:
  - Adds output stack_fault (1 bit, registered, sticky until reset).
  - A push at SP==0 or a pop at SP==SP_INIT is suppressed: no write, SP unchanged, reg_write_out=0, pc_load_out=0, no FSM entry. stack_fault <= 1.
- Undefined: no port, silent wrap as above.

Test Plan:
- Reset release -> sp_out=12'hFFF, all registered outputs 0, stall=0.
- Store: ex_mem_write=1, addr_sel=00, ex_result=16'h0010, ex_read_data2=16'hBEEF -> dmem_we=1, dmem_addr=0x010, dmem_wdata=BEEF. Next cycle load same address, dmem_rdata=BEEF -> mem_data_out=BEEF one edge later.
- One-word push then pop of 16'h1234 -> write at 0xFFF, SP=0xFFE; pop reads 0xFFF, mem_data_out=1234, SP=0xFFF.
- PC push: ex_pc_plus_one=32'h0001_0042 -> stall high 1 cycle, mem[FFF]=0001, mem[FFE]=0042, SP=0xFFD. Then PC pop -> stall 1 cycle, pc_out=32'h0001_0042, pc_load_out pulse of 1 cycle, SP=0xFFF.
- Push and pop asserted together with ex_read_data2=16'h00AA -> treated as push: mem[SP]=00AA, SP decremented.
- Reset asserted during the PUSH_LO cycle -> state IDLE, stall=0, SP=0xFFF. With STACK_GUARD_EN, a pop at SP=0xFFF -> stack_fault=1, SP unchanged.

Source files
------------

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Memory pipeline stage: data-memory load/store, stack push/pop, SP, MEM/WB buffer.
// Optional STACK_GUARD_EN adds a sticky stack_fault output and suppresses stack overflow/underflow.
module memory_stage #(
  parameter int                ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] SP_INIT = 12'hFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ex_result,
  input  logic [15:0]       ex_read_data1,
  input  logic [15:0]       ex_read_data2,
  input  logic [31:0]       ex_pc_plus_one,
  input  logic [2:0]        ex_flags,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_push,
  input  logic              ex_mem_pop,
  input  logic [1:0]        ex_addr_sel,
  input  logic [1:0]        ex_wsrc_sel,
  input  logic              ex_pc_choose_memory,
  input  logic              ex_reg_write,
  input  logic [2:0]        ex_reg_write_address,
  input  logic [1:0]        ex_wb_sel,
  input  logic [15:0]       ex_ldm_value,
  input  logic [15:0]       ex_input_port,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  output logic              dmem_we,
  input  logic [15:0]       dmem_rdata,
  output logic              stall,
  output logic [15:0]       mem_data_out,
  output logic [31:0]       pc_out,
  output logic              pc_load_out,
  output logic [15:0]       result_out,
  output logic              reg_write_out,
  output logic [2:0]        reg_write_address_out,
  output logic [1:0]        wb_sel_out,
  output logic [15:0]       ldm_value_out,
  output logic [15:0]       input_port_out,
`ifdef STACK_GUARD_EN
  output logic              stack_fault,
`endif
  output logic [ADDR_W-1:0] sp_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PUSH_LO = 2'd1;
  localparam logic [1:0] S_POP_HI  = 2'd2;
  localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       lo_hold_q, lo_hold_d;
  logic [15:0]       mem_data_q, mem_data_d;
  logic [31:0]       pc_q, pc_d;
  logic              pc_load_q, pc_load_d;
  logic              reg_write_q, reg_write_d;
  logic [15:0]       result_q, ldm_q, inport_q;
  logic [2:0]        rwa_q;
  logic [1:0]        wb_sel_q;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] sp_inc, sp_dec, sel_addr, addr_c;
  logic [15:0]       wsrc_data, wdata_c;
  logic              we_c, stall_c;
  logic              do_push, do_pop, do_write, do_read, push_ok, pop_ok;

  always_comb begin
    sp_inc   = sp_q + SP_ONE;
    sp_dec   = sp_q - SP_ONE;
    do_push  = ex_mem_push;
    do_pop   = ~ex_mem_push & ex_mem_pop;
    do_write = ~ex_mem_push & ~ex_mem_pop & ex_mem_write;
    do_read  = ~ex_mem_push & ~ex_mem_pop & ~ex_mem_write & ex_mem_read;
`ifdef STACK_GUARD_EN
    push_ok  = (sp_q != '0);
    pop_ok   = (sp_q != SP_INIT);
`else
    push_ok  = 1'b1;
    pop_ok   = 1'b1;
`endif
    case (ex_addr_sel)
      2'b01:   sel_addr = ex_read_data1[ADDR_W-1:0];
      2'b10:   sel_addr = sp_q;
      default: sel_addr = ex_result[ADDR_W-1:0];
    endcase
    case (ex_wsrc_sel)
      2'b00:   wsrc_data = ex_read_data2;
      2'b01:   wsrc_data = ex_read_data1;
      2'b10:   wsrc_data = ex_pc_plus_one[31:16];
      default: wsrc_data = {13'b0, ex_flags};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    lo_hold_d   = lo_hold_q;
    mem_data_d  = mem_data_q;
    pc_d        = pc_q;
    pc_load_d   = 1'b0;
    reg_write_d = ex_reg_write;
    fault_d     = fault_q;
    addr_c      = ex_result[ADDR_W-1:0];
    wdata_c     = wsrc_data;
    we_c        = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      // Second halves run off the ex_* values upstream holds during the stall.
      S_PUSH_LO: begin
        we_c    = 1'b1;
        addr_c  = sp_q;
        wdata_c = ex_pc_plus_one[15:0];
        sp_d    = sp_dec;
        state_d = S_IDLE;
      end
      S_POP_HI: begin
        addr_c    = sp_inc;
        pc_d      = {dmem_rdata, lo_hold_q};
        pc_load_d = 1'b1;
        sp_d      = sp_inc;
        state_d   = S_IDLE;
      end
      default: begin
        if (do_push) begin
          if (!push_ok) begin
            reg_write_d = 1'b0;
            fault_d     = 1'b1;
          end else begin
            we_c   = 1'b1;
            addr_c = sp_q;
            sp_d   = sp_dec;
            if (ex_wsrc_sel == 2'b10) begin
              stall_c     = 1'b1;
              reg_write_d = 1'b0;
              state_d     = S_PUSH_LO;
            end
          end
        end else if (do_pop) begin
          if (!pop_ok) begin
            reg_write_d = 1'b0;
            fault_d     = 1'b1;
          end else begin
            addr_c = sp_inc;
            sp_d   = sp_inc;
            if (ex_pc_choose_memory) begin
              lo_hold_d   = dmem_rdata;
              stall_c     = 1'b1;
              reg_write_d = 1'b0;
              state_d     = S_POP_HI;
            end else begin
              mem_data_d = dmem_rdata;
            end
          end
        end else if (do_write) begin
          we_c   = 1'b1;
          addr_c = sel_addr;
        end else if (do_read) begin
          addr_c     = sel_addr;
          mem_data_d = dmem_rdata;
        end
      end
    endcase
  end

  // Strobes are masked while reset is held so no write lands during reset.
  assign dmem_addr  = addr_c;
  assign dmem_wdata = wdata_c;
  assign dmem_we    = we_c & reset;
  assign stall      = stall_c & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sp_q        <= SP_INIT;
      lo_hold_q   <= '0;
      mem_data_q  <= '0;
      pc_q        <= '0;
      pc_load_q   <= 1'b0;
      reg_write_q <= 1'b0;
      result_q    <= '0;
      rwa_q       <= '0;
      wb_sel_q    <= '0;
      ldm_q       <= '0;
      inport_q    <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      lo_hold_q   <= lo_hold_d;
      mem_data_q  <= mem_data_d;
      pc_q        <= pc_d;
      pc_load_q   <= pc_load_d;
      reg_write_q <= reg_write_d;
      result_q    <= ex_result;
      rwa_q       <= ex_reg_write_address;
      wb_sel_q    <= ex_wb_sel;
      ldm_q       <= ex_ldm_value;
      inport_q    <= ex_input_port;
      fault_q     <= fault_d;
    end
  end

  assign mem_data_out          = mem_data_q;
  assign pc_out                = pc_q;
  assign pc_load_out           = pc_load_q;
  assign result_out            = result_q;
  assign reg_write_out         = reg_write_q;
  assign reg_write_address_out = rwa_q;
  assign wb_sel_out            = wb_sel_q;
  assign ldm_value_out         = ldm_q;
  assign input_port_out        = inport_q;
  assign sp_out                = sp_q;
`ifdef STACK_GUARD_EN
  assign stack_fault           = fault_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - Directed scoreboard bench for memory_stage (also builds with STACK_GUARD_EN).
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ex_result, ex_read_data1, ex_read_data2, ex_ldm_value, ex_input_port;
  logic [31:0] ex_pc_plus_one;
  logic [2:0]  ex_flags, ex_reg_write_address;
  logic        ex_mem_read, ex_mem_write, ex_mem_push, ex_mem_pop;
  logic [1:0]  ex_addr_sel, ex_wsrc_sel, ex_wb_sel;
  logic        ex_pc_choose_memory, ex_reg_write;
  logic [11:0] dmem_addr, sp_out;
  logic [15:0] dmem_wdata, dmem_rdata, mem_data_out, result_out, ldm_value_out, input_port_out;
  logic        dmem_we, stall, pc_load_out, reg_write_out;
  logic [31:0] pc_out;
  logic [2:0]  reg_write_address_out;
  logic [1:0]  wb_sel_out;
`ifdef STACK_GUARD_EN
  logic        stack_fault;
`endif

  logic [15:0] mem [4096] = '{default: 16'h0000};

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage dut (
    .clk(clk), .reset(reset),
    .ex_result(ex_result), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_pc_plus_one(ex_pc_plus_one), .ex_flags(ex_flags),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_push(ex_mem_push), .ex_mem_pop(ex_mem_pop),
    .ex_addr_sel(ex_addr_sel), .ex_wsrc_sel(ex_wsrc_sel),
    .ex_pc_choose_memory(ex_pc_choose_memory), .ex_reg_write(ex_reg_write),
    .ex_reg_write_address(ex_reg_write_address), .ex_wb_sel(ex_wb_sel),
    .ex_ldm_value(ex_ldm_value), .ex_input_port(ex_input_port),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .stall(stall), .mem_data_out(mem_data_out), .pc_out(pc_out), .pc_load_out(pc_load_out),
    .result_out(result_out), .reg_write_out(reg_write_out),
    .reg_write_address_out(reg_write_address_out), .wb_sel_out(wb_sel_out),
    .ldm_value_out(ldm_value_out), .input_port_out(input_port_out),
`ifdef STACK_GUARD_EN
    .stack_fault(stack_fault),
`endif
    .sp_out(sp_out)
  );

  always #5 clk = ~clk;

  assign dmem_rdata = mem[dmem_addr];
  always @(posedge clk) if (dmem_we) mem[dmem_addr] <= dmem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_entry_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic idle_inputs();
    ex_result = '0; ex_read_data1 = '0; ex_read_data2 = '0; ex_pc_plus_one = '0;
    ex_flags = '0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_push = 0; ex_mem_pop = 0;
    ex_addr_sel = '0; ex_wsrc_sel = '0; ex_pc_choose_memory = 0; ex_reg_write = 0;
    ex_reg_write_address = '0; ex_wb_sel = '0; ex_ldm_value = '0; ex_input_port = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp", sp_out, 32'hFFF);
    chk("rst_stall", stall, 0);
    chk("rst_outs", {mem_data_out, result_out, reg_write_out, pc_load_out}, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_pass", {reg_write_address_out, wb_sel_out, ldm_value_out, input_port_out}, 0);
`ifdef STACK_GUARD_EN
    chk("rst_fault", stack_fault, 0);
`endif
    @(negedge clk) reset = 1'b1;

    // store BEEF at 0x010
    @(negedge clk);
    ex_mem_write = 1; ex_result = 16'h0010; ex_read_data2 = 16'hBEEF;
    #1;
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h010);
    chk("st_wdata", dmem_wdata, 32'hBEEF);
    tick();
    chk("st_mem", mem[12'h010], 32'hBEEF);

    // load it back, with pass-throughs
    @(negedge clk);
    idle_inputs();
    ex_mem_read = 1; ex_result = 16'h0010; ex_reg_write = 1; ex_reg_write_address = 3'd5;
    ex_wb_sel = 2'd2; ex_ldm_value = 16'h1111; ex_input_port = 16'h2222;
    sb_push("ld_data", 32'hBEEF);
    tick();
    sb_check(mem_data_out);
    chk("ld_pass", {result_out, reg_write_out, reg_write_address_out, wb_sel_out},
        {16'h0010, 1'b1, 3'd5, 2'd2});
    chk("ld_pass2", {ldm_value_out, input_port_out}, 32'h1111_2222);

    // one-word push / pop
    @(negedge clk);
    idle_inputs();
    ex_mem_push = 1; ex_read_data2 = 16'h1234; ex_addr_sel = 2'b10;
    #1;
    chk("push_addr", dmem_addr, 32'hFFF);
    tick();
    chk("push_sp", sp_out, 32'hFFE);
    chk("push_mem", mem[12'hFFF], 32'h1234);
    @(negedge clk);
    idle_inputs();
    ex_mem_pop = 1; ex_addr_sel = 2'b10;
    #1;
    chk("pop_addr", dmem_addr, 32'hFFF);
    sb_push("pop_data", 32'h1234);
    tick();
    sb_check(mem_data_out);
    chk("pop_sp", sp_out, 32'hFFF);

    // two-word PC push
    @(negedge clk);
    idle_inputs();
    ex_mem_push = 1; ex_wsrc_sel = 2'b10; ex_pc_plus_one = 32'h0001_0042; ex_reg_write = 1;
    #1;
    chk("pcpush_stall1", stall, 1);
    chk("pcpush_hi", {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 12'hFFF, 16'h0001});
    tick();
    chk("pcpush_bubble", reg_write_out, 0);
    chk("pcpush_stall2", stall, 0);
    chk("pcpush_lo", {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 12'hFFE, 16'h0042});
    tick();
    chk("pcpush_sp", sp_out, 32'hFFD);
    chk("pcpush_mem", {mem[12'hFFF], mem[12'hFFE]}, 32'h0001_0042);
    chk("pcpush_rw", reg_write_out, 1);

    // two-word PC pop
    @(negedge clk);
    idle_inputs();
    ex_mem_pop = 1; ex_pc_choose_memory = 1; ex_reg_write = 1;
    #1;
    chk("pcpop_stall1", stall, 1);
    chk("pcpop_addr1", dmem_addr, 32'hFFE);
    sb_push("pcpop_pc", 32'h0001_0042);
    tick();
    chk("pcpop_bubble", {pc_load_out, reg_write_out}, 0);
    chk("pcpop_stall2", stall, 0);
    chk("pcpop_addr2", dmem_addr, 32'hFFF);
    tick();
    sb_check(pc_out);
    chk("pcpop_load", pc_load_out, 1);
    chk("pcpop_sp", sp_out, 32'hFFF);
    @(negedge clk);
    idle_inputs();
    tick();
    chk("pcpop_pulse_end", pc_load_out, 0);

    // push and pop together: push wins
    @(negedge clk);
    ex_mem_push = 1; ex_mem_pop = 1; ex_read_data2 = 16'h00AA;
    tick();
    chk("prio_mem", mem[12'hFFF], 32'h00AA);
    chk("prio_sp", sp_out, 32'hFFE);
    @(negedge clk);
    idle_inputs();
    ex_mem_pop = 1; ex_mem_write = 1; ex_read_data2 = 16'hDEAD; ex_result = 16'h0020;
    sb_push("prio_pop", 32'h00AA);
    #1;
    chk("prio_pop_we", dmem_we, 0);
    tick();
    sb_check(mem_data_out);
    chk("prio_pop_sp", sp_out, 32'hFFF);

    // reset during PUSH_LO
    @(negedge clk);
    idle_inputs();
    ex_mem_push = 1; ex_wsrc_sel = 2'b10; ex_pc_plus_one = 32'h0003_0007;
    tick();
    chk("rstmid_sp_pre", sp_out, 32'hFFE);
    #1;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rstmid_stall", stall, 0);
    chk("rstmid_sp", sp_out, 32'hFFF);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    ex_mem_push = 1; ex_read_data2 = 16'h7777;
    #1;
    chk("rstmid_idle", {stall, dmem_addr, dmem_wdata}, {1'b0, 12'hFFF, 16'h7777});
    tick();
    chk("rstmid_push_sp", sp_out, 32'hFFE);
    @(negedge clk);
    idle_inputs();
    ex_mem_pop = 1;
    sb_push("rstmid_pop", 32'h7777);
    tick();
    sb_check(mem_data_out);

    // pop at SP=0xFFF: guarded fault, or wrap to 0 then push wraps back
    @(negedge clk);
    idle_inputs();
    ex_mem_pop = 1; ex_reg_write = 1;
`ifdef STACK_GUARD_EN
    tick();
    chk("guard_sp", sp_out, 32'hFFF);
    chk("guard_fault", stack_fault, 1);
    chk("guard_rw", reg_write_out, 0);
    @(negedge clk);
    idle_inputs();
    tick();
    chk("guard_sticky", stack_fault, 1);
`else
    #1;
    chk("wrap_pop_addr", dmem_addr, 32'h000);
    sb_push("wrap_pop_data", 32'h0000);
    tick();
    sb_check(mem_data_out);
    chk("wrap_pop_sp", sp_out, 32'h000);
    @(negedge clk);
    idle_inputs();
    ex_mem_push = 1; ex_read_data2 = 16'h5555;
    tick();
    chk("wrap_push_mem", mem[12'h000], 32'h5555);
    chk("wrap_push_sp", sp_out, 32'hFFF);
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
